// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter: shares one memory port between the
// instruction-fetch and data requesters, with round-robin grant on ties.
module mem_arbiter #(
    parameter int unsigned LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        m_en,
    output logic        m_wr,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    localparam int unsigned CNT_W = 2;
    localparam logic GNT_FETCH = 1'b0;
    localparam logic GNT_DATA  = 1'b1;

    if (LAT < 1 || LAT > 3) begin : g_bad_lat
        $error("mem_arbiter: LAT must be in 1..3");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state, state_d;
    logic               last_grant;
    logic               lat_wr;
    logic [CNT_W-1:0]   cnt;
    logic               win_data;
    logic               m_en_d, m_wr_d, i_ack_d, d_ack_d, busy_d;

    // Data wins when it is alone, or on a tie when fetch was granted last.
    assign win_data = d_req && (!i_req || (last_grant == GNT_FETCH));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (i_req || d_req) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (cnt == '0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered strobes; the write strobe in ISSUE comes
    // from the winner directly because lat_wr is loaded on the same edge.
    always_comb begin
        m_en_d  = 1'b0;
        m_wr_d  = 1'b0;
        i_ack_d = 1'b0;
        d_ack_d = 1'b0;
        busy_d  = (state_d != IDLE);
        if (state == IDLE && state_d == ISSUE) begin
            m_en_d = 1'b1;
            m_wr_d = win_data && d_wr;
        end
        if (state_d == RESP) begin
            i_ack_d = (last_grant == GNT_FETCH);
            d_ack_d = (last_grant == GNT_DATA);
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_en  <= 1'b0;
            m_wr  <= 1'b0;
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            busy  <= 1'b0;
        end else begin
            m_en  <= m_en_d;
            m_wr  <= m_wr_d;
            i_ack <= i_ack_d;
            d_ack <= d_ack_d;
            busy  <= busy_d;
        end
    end

    // Request latch, latency counter and read-data capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= GNT_DATA;
            lat_wr     <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            cnt        <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            if (state == IDLE && state_d == ISSUE) begin
                last_grant <= win_data;
                lat_wr     <= win_data && d_wr;
                m_addr     <= win_data ? d_addr : i_addr;
                m_wdata    <= win_data ? d_wdata : '0;
            end
            if (state == ISSUE) begin
                cnt <= CNT_W'(LAT - 1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (state == WAIT && cnt == '0) begin
                if (last_grant == GNT_FETCH) begin
                    i_rdata <= m_rdata;
                end else if (!lat_wr) begin
                    d_rdata <= m_rdata;
                end
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LAT, default 1, memory read latency in clock cycles from issue to valid m_rdata; legal range 1..3; any other value SHALL be an elaboration error.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 i_req  input  1  instruction-fetch request, held high until i_ack.
REQ-005 i_addr  input  32  fetch address.
REQ-006 i_ack  output  1  one-cycle fetch completion pulse.
REQ-007 i_rdata  output  32  registered fetch data.
REQ-008 d_req  input  1  data request, held high until d_ack.
REQ-009 d_wr  input  1  1 = store, 0 = load.
REQ-010 d_addr  input  32  data address.
REQ-011 d_wdata  input  32  store data.
REQ-012 d_ack  output  1  one-cycle data completion pulse.
REQ-013 d_rdata  output  32  registered load data.
REQ-014 m_en  output  1  memory port enable, one-cycle issue strobe.
REQ-015 m_wr  output  1  memory write strobe.
REQ-016 m_addr  output  32  memory address.
REQ-017 m_wdata  output  32  memory write data.
REQ-018 m_rdata  input  32  memory read data.
REQ-019 busy  output  1  high whenever state is not IDLE.

Function
REQ-020 The block SHALL share one memory port between the fetch and data requesters using the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-021 In IDLE, with any req high, the FSM SHALL select a requester, latch its address, write-data and wr into internal registers, and move to ISSUE on the next edge.
REQ-022 With no req high, the FSM SHALL stay in IDLE.
REQ-023 On arbitration: if only one requester is active it SHALL win; on a tie, the requester not granted last SHALL win (round-robin on last_grant).
REQ-024 ISSUE SHALL last exactly one cycle, with m_en=1, m_addr/m_wdata from the latched values and m_wr=latched wr (0 for fetch), then move to WAIT.
REQ-025 WAIT SHALL count LAT cycles with a 2-bit down-counter loaded on ISSUE; on the final WAIT cycle, m_rdata SHALL be captured into the winner's rdata register (loads and fetches only), then the FSM SHALL move to RESP.
REQ-026 RESP SHALL last one cycle with the winner's ack=1, then return to IDLE.
REQ-027 Total latency from the IDLE cycle sampling req to the ack cycle SHALL be LAT+2 cycles; back-to-back issue spacing SHALL be LAT+3 cycles.
REQ-028 Outside ISSUE, m_en and m_wr SHALL be 0; m_addr/m_wdata SHALL hold their latched values.
REQ-029 Requester inputs changing after the latch cycle SHALL be ignored until the next arbitration.
REQ-030 A requester SHALL have its req sampled again only in IDLE; a req still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-031 A store SHALL leave d_rdata unchanged; the non-winning rdata register SHALL never change.
REQ-032 Acks SHALL be mutually exclusive and never asserted outside RESP.
REQ-033 last_grant SHALL update when the FSM leaves IDLE.

Reset
REQ-034 While rst=0, the block SHALL be in IDLE with busy, m_en, m_wr, i_ack and d_ack at 0, m_addr, m_wdata, i_rdata, d_rdata and the counter at 0, and last_grant=DATA, so the first tie goes to fetch.
REQ-035 Reset asserted mid-transaction SHALL abort it immediately without issuing an ack; after release, the FSM SHALL resume from IDLE.

Verification
REQ-036 LAT=1, i_req only, i_addr=0x10, m_rdata=0xDEADBEEF: the bench SHALL see m_en=1 at cycle 1 with m_addr=0x10, then i_ack=1 at cycle 3 with i_rdata=0xDEADBEEF, and d_ack=0 throughout.
REQ-037 LAT=1, i_req and d_req both held high from reset: the bench SHALL see grants in the order fetch, data, fetch, with acks at cycles 3, 7 and 11.
REQ-038 d_req with d_wr=1, d_addr=0x200, d_wdata=0x1234: the bench SHALL see m_en=m_wr=1 for exactly one cycle with m_wdata=0x1234, then d_ack after LAT+2 cycles, with d_rdata unchanged.
REQ-039 LAT=3, single load: the bench SHALL see d_ack exactly 5 cycles after the sampling IDLE cycle, with busy high for 5 cycles.
REQ-040 rst pulled low during WAIT: the bench SHALL see no ack, all outputs at their reset values, and, after release, a pending i_req served normally.
REQ-041 i_addr changed from 0x10 to 0x20 during WAIT: the bench SHALL see m_addr stay 0x10 and the returned data correspond to 0x10.
